// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Byte offsets within the 8-byte register window
  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  // STATUS word layout
  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_CNT_LSB   = 4;
  localparam int unsigned ST_CNT_W     = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational read port (dout shows the head entry).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         din,
  output logic [Width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CountW'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage array carries no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, byte FIFO, STATUS readback and
// serialiser FSM. Stores never stall; a store to a full FIFO is dropped and flagged.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Sel,
  output logic [31:0] RdData,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [CntW-1:0]   baud_q;
  logic              baud_done;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              ovf_q;
  logic              wr_data, wr_status, rd_status;
  logic              pop, full, empty;
  logic [7:0]        fifo_dout;
  logic [CountW-1:0] count;
  logic [31:0]       status;
  logic              unused_bits;

  // Byte-lane select and upper data bits carry no meaning for this block
  assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

  assign Sel       = (ALUResult[31:3] == BASE_ADDR[31:3]);
  assign wr_data   = MemWrite & Sel & (ALUResult[2] == TXDATA_OFS[2]);
  assign wr_status = MemWrite & Sel & (ALUResult[2] == STATUS_OFS[2]);
  assign rd_status = Sel & (ALUResult[2] == STATUS_OFS[2]);
  assign baud_done = (baud_q == CntMax);
  assign busy      = (state_q != IDLE);

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow: set by a dropped push, cleared by any store to STATUS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (wr_status) begin
      ovf_q <= 1'b0;
    end else if (wr_data && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  // STATUS word assembly and read mux (TXDATA reads as zero)
  always_comb begin
    status = '0;
    status[ST_FULL_BIT]  = full;
    status[ST_EMPTY_BIT] = empty;
    status[ST_BUSY_BIT]  = busy;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
    RdData = rd_status ? status : '0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state; STOP chains straight into START when more bytes are queued
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   if (baud_done) state_d = DATA;
      DATA:    if (baud_done && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_done) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: line level and FIFO pop
  always_comb begin
    tx  = 1'b1;
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = ~empty;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      STOP:    pop = baud_done & ~empty;
      default: tx = 1'b1;
    endcase
  end

  // Baud counter restarts on every bit or state boundary and rests at 0 in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q <= '0;
    end else if (state_q == IDLE || baud_done) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + CntW'(1);
    end
  end

  // Data bit index and LSB-first shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_q != DATA)  bit_q <= '0;
      else if (baud_done)   bit_q <= bit_q + 3'd1;
      if (pop)                            shift_q <= fifo_dout;
      else if (state_q == DATA && baud_done) shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, directed multi-cycle sequences and a random
// store/read mix, all checked cycle by cycle against a frame-timing reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] UNMAPPED = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = UNMAPPED;
  logic [31:0] WriteData = '0;
  logic        Sel, tx, busy;
  logic [31:0] RdData;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .Sel       (Sel),
    .RdData    (RdData),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; a frame is a start time plus a byte, and the
  // line level follows from the elapsed time within the frame.
  int         cyc = 0;
  logic [7:0] q[$];
  bit         fa = 0;
  int         fs = 0;
  logic [7:0] fb = '0;
  bit         m_ovf = 0;

  function automatic bit m_sel(input logic [31:0] a);
    logic [31:0] b = BASE;
    return a[31:3] == b[31:3];
  endfunction

  function automatic int frame_pos();
    return fa ? (cyc - 1 - fs) : -1;
  endfunction

  function automatic logic m_busy();
    int e = frame_pos();
    return (e >= 0) && (e < FRAME);
  endfunction

  function automatic logic m_tx();
    int e = frame_pos();
    int k;
    if (!m_busy()) return 1'b1;
    k = e / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fb[k-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0]   = (q.size() == DEPTH);
    s[1]   = (q.size() == 0);
    s[2]   = m_busy();
    s[3]   = m_ovf;
    s[7:4] = 4'(q.size());
    return s;
  endfunction

  function automatic void model_edge(input logic mw, input logic [31:0] a, input logic [31:0] d);
    int n = cyc;
    if (fa && (n - fs) >= FRAME) fa = 0;
    if (!fa && q.size() != 0) begin
      fb = q.pop_front();
      fs = n;
      fa = 1;
    end
    if (mw && m_sel(a)) begin
      if (!a[2]) begin
        if (q.size() < DEPTH) q.push_back(d[7:0]);
        else m_ovf = 1;
      end else begin
        m_ovf = 0;
      end
    end
    cyc = n + 1;
  endfunction

  function automatic void model_reset();
    q.delete();
    fa = 0;
    m_ovf = 0;
  endfunction

  // One bus cycle: drive, check combinational decode/readback, clock, check line and busy
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = mw;
    ALUResult = a;
    WriteData = d;
    #2;
    chk("sel", {31'b0, Sel}, {31'b0, m_sel(a)});
    if (!mw && m_sel(a)) chk("rddata", RdData, a[2] ? m_status() : 32'h0);
    @(posedge clk);
    model_edge(mw, a, d);
    #1;
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    chk("busy", {31'b0, busy}, {31'b0, m_busy()});
    if (busy === 1'b1) busy_cycles++;
    MemWrite  = 1'b0;
    ALUResult = UNMAPPED;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, UNMAPPED, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * FRAME + 10; i++) begin
      if (!m_busy() && q.size() == 0) break;
      step(1'b0, UNMAPPED, 32'h0);
    end
    chk("drained_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic rd_status_now(input string name, input logic [31:0] exp);
    MemWrite  = 1'b0;
    ALUResult = BASE + 32'h4;
    #1;
    chk(name, RdData, exp);
    ALUResult = UNMAPPED;
  endtask

  // Asynchronous reset in the middle of a cycle, then realign to posedge+1
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_tx", {31'b0, tx}, 32'h1);
    chk("rst_async_busy", {31'b0, busy}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] a;

    vt[0] = '{BASE + 32'h0,  1'b1, 32'h0};
    vt[1] = '{BASE + 32'h4,  1'b1, 32'h2};
    vt[2] = '{BASE + 32'h5,  1'b1, 32'h2};
    vt[3] = '{BASE + 32'h7,  1'b1, 32'h2};
    vt[4] = '{BASE + 32'h3,  1'b1, 32'h0};
    vt[5] = '{BASE + 32'h8,  1'b0, 32'h0};
    vt[6] = '{32'h0,         1'b0, 32'h0};
    vt[7] = '{32'h8000_1004, 1'b0, 32'h0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    // Decode table at reset state (reads only)
    foreach (vt[i]) begin
      ALUResult = vt[i].addr;
      #1;
      chk($sformatf("tbl_sel[%0d]", i), {31'b0, Sel}, {31'b0, vt[i].exp_sel});
      chk($sformatf("tbl_rd[%0d]", i), RdData, vt[i].exp_rd);
    end
    ALUResult = UNMAPPED;
    @(posedge clk);
    #1;

    // Single byte A5: line falls one cycle after the store edge, 40 busy cycles
    busy_cycles = 0;
    step(1'b1, BASE, 32'hA5);
    chk("a5_idle_at_store_edge", {31'b0, tx}, 32'h1);
    step(1'b0, UNMAPPED, 32'h0);
    chk("a5_start_bit", {31'b0, tx}, 32'h0);
    idle(45);
    chk("a5_busy_cycles", busy_cycles, 41 - 1);

    // Five back-to-back stores: no loss, no overflow, 200 contiguous busy cycles
    busy_cycles = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, BASE, i);
    rd_status_now("five_status", 32'h45);
    drain();
    chk("five_busy_cycles", busy_cycles, 200);

    // Six stores: sixth dropped, overflow sticky until a STATUS store
    for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'h10 + i);
    rd_status_now("six_ovf", 32'h4D);
    step(1'b1, BASE + 32'h4, 32'hFFFF_FFFF);
    rd_status_now("ovf_cleared", 32'h45);
    drain();

    // Reset during DATA bit 3 (0x37 has bit 3 clear, so the line is low there)
    step(1'b1, BASE, 32'h37);
    step(1'b1, BASE, 32'h99);
    idle(17);
    chk("pre_reset_tx_low", {31'b0, tx}, 32'h0);
    do_reset();
    busy_cycles = 0;
    idle(50);
    chk("post_reset_no_frame", busy_cycles, 0);
    rd_status_now("post_reset_status", 32'h2);

    // Stores outside the TXDATA register
    busy_cycles = 0;
    ALUResult = BASE + 32'h8;
    #1;
    chk("sel_base8", {31'b0, Sel}, 32'h0);
    step(1'b1, BASE + 32'h8, 32'h55);
    step(1'b1, UNMAPPED, 32'h55);
    idle(5);
    chk("decode_no_frame", busy_cycles, 0);
    rd_status_now("decode_status", 32'h2);

    // Random mix of stores, STATUS stores, reads and unmapped traffic
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        step(1'b1, BASE | 32'($urandom_range(0, 3)), $urandom);
      end else if (r < 15) begin
        step(1'b1, BASE + 32'h4 + 32'($urandom_range(0, 3)), $urandom);
      end else if (r < 25) begin
        step(1'b0, BASE + 32'($urandom_range(0, 7)), 32'h0);
      end else if (r < 30) begin
        a = $urandom;
        step(1'b1, a, $urandom);
      end else begin
        step(1'b0, UNMAPPED, 32'h0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the core. It decodes the core's store address and data and queues bytes in a small FIFO. It serialises the bytes as 8N1 frames on `tx` and exposes a status word to the data-memory read mux. It gives programs running on the core a console/debug output without stalling the single-cycle pipeline.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: word-aligned base of the 8-byte register window.
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO depth. Power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe from the core.
- `ALUResult`  in  32  byte address from the core.
- `WriteData`  in  32  store data from the core.
- `Sel`  out  1  combinational; high when `ALUResult[31:3] == BASE_ADDR[31:3]`. Steers the read mux.
- `RdData`  out  32  combinational register readback.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Register map, word-aligned; `ALUResult[1:0]` is ignored:
  - BASE+0 TXDATA, write-only. A store pushes `WriteData[7:0]`. Reads return 0.
  - BASE+4 STATUS. Bit 0 full, bit 1 empty, bit 2 busy, bit 3 overflow (sticky). Bits [7:4] hold the FIFO count. Other bits read 0. Any store to BASE+4 clears overflow.
- Push condition: `MemWrite & Sel & ~ALUResult[2]`.
  - Push when full with no pop in the same cycle: byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: push is accepted and count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop into the shift register and go to START. Otherwise stay.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, for `CLKS_PER_BIT` cycles per bit. After bit 7 go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then, if FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT`-1 and clears on every state or bit change. Counter width is `$clog2(CLKS_PER_BIT)`.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. Count is one bit wider.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, FIFO empty (count 0), overflow 0. `RdData` reads STATUS = 32'h2 when addressed.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronous) and queued bytes are discarded.
- Store at edge E0 with FSM idle: at E1 the FSM pops and enters START. `tx` falls after E1, i.e. 1 cycle of latency from the store edge.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. `busy` covers the whole frame, including back-to-back frames.
- STATUS reflects register state of the current cycle. A store and a STATUS read never coincide, because the core issues one access per cycle.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Register offsets `TXDATA_OFS`=0 and `STATUS_OFS`=4.
  - STATUS bit-position constants.
- Sub-module `sync_fifo`, parameterised by width and depth. Ports: push, pop, din, dout, full, empty, count. Same clock and reset.
- The top contains the decode, STATUS mux, overflow flag, FSM, baud counter and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset → `tx`=1, `busy`=0, STATUS read = 32'h2.
- Store 8'hA5 to BASE+0 → `tx` low 1 cycle after the store edge. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. `busy` high for 40 cycles.
- Five stores (8'h01–8'h05) on consecutive cycles while idle:
  - The first is popped immediately, so the FIFO takes the remaining four without loss and overflow stays 0.
  - Frames are back-to-back, 200 cycles total, with no extra idle cycle between stop and start.
- Six consecutive stores → the sixth is dropped and STATUS bit 3 = 1. A store to BASE+4 clears it; STATUS then shows overflow 0.
- Assert `reset` low during DATA bit 3 → `tx` is 1 asynchronously. After release, no residual frame and STATUS = 32'h2.
- Store to BASE+8 and to an unrelated address → `Sel`=0, no push, `tx` stays high.
